raizing_vtimer_prog: RTL
========================

# raizing_vtimer_prog

Run-time programmable video timing generator for the Raizing video pipeline. It counts pixels and lines on the 96 MHz domain under `pxl_cen` and produces blanking, sync, dump/render line counters and frame/line interrupt pulses. All geometry lives in CPU/GCU-writable staging registers, which are committed to the active set only at frame start so that a write never tears a frame. Reset defaults give the standard 432×263 layout (320×240 active).

## Interface
Parameters:
- `W`, 9: width of counters, timing registers and `cfg_data`.
- `H_LAST`, 431: default last H count (432 px/line).
- `H_ACT`, 320: default active pixels/line.
- `HS_START`, 360: default HS rise.
- `HS_END`, 380: default HS fall.
- `V_LAST`, 262: default last V count (263 lines).
- `V_ACT`, 240: default active lines.
- `VS_START`, 244: default VS rise.
- `VS_END`, 249: default VS fall.

Ports:
- `clk96` in 1: only clock.
- `reset96_n` in 1: **synchronous, active-low reset.**
- `pxl_cen` in 1: pixel clock enable.
- `flip` in 1: vertical flip request; sampled at frame start.
- `cfg_we` in 1: staging register write strobe.
- `cfg_addr` in 4: register select.
- `cfg_data` in W: write data.
- `cfg_dout` out W: registered readback of staging register at `cfg_addr`.
- `hpos` out W: current pixel count H.
- `vpos` out W: current line count V (vdump).
- `vrender` out W: render line, flip-corrected.
- `lhbl` out 1: high = horizontal active.
- `lvbl` out 1: high = vertical active.
- `hsync` out 1: high during HS.
- `vsync` out 1: high during VS.
- `display_on` out 1: `lhbl & lvbl`.
- `frame_start` out 1: one-clk96 pulse at H=0, V=0.
- `line_irq` out 1: one-clk96 pulse at H=0, V=irq_line when enabled.

## Operation
- Register map (`cfg_addr`):
  - 0 h_last; 1 h_act; 2 hs_start; 3 hs_end
  - 4 v_last; 5 v_act; 6 vs_start; 7 vs_end
  - 8 irq_line; 9 ctrl (bit0 irq_en)
  - 10–15 write-ignored, read 0
- Staging register updates on the clk96 edge where `cfg_we` is high. Writes are independent of `pxl_cen`.
- `cfg_dout` equals staging[`cfg_addr`] one clk96 after `cfg_addr` is presented.
- Counters advance only on cycles with `pxl_cen`=1:
  - H: if H == h_last, H←0; else H←H+1.
  - V: advances only when H wraps. If V == v_last, V←0; else V←V+1.
- Commit: on the `pxl_cen` edge where H and V both wrap to 0, all active registers ← staging and flip_q ← `flip`.
- Outputs are registered and describe the H/V value present in the same cycle. They use the active register set only.
  - lhbl = H < h_act; lvbl = V < v_act.
  - hsync = hs_start ≤ H < hs_end; vsync = vs_start ≤ V < vs_end.
  - Comparisons are unsigned W-bit with no clamping. Inconsistent programming (e.g. h_act > h_last) yields constant levels, not errors.
- vrender:
  - vr = (V == v_last) ? 0 : V+1.
  - Output is flip_q ? (v_act − vr) mod 2^W : vr.
- `frame_start` and `line_irq` are high for exactly the one clk96 cycle in which the new H=0 value is first presented.
  - `line_irq` requires irq_en = 1 (active) and new V == irq_line.
  - If irq_line > v_last, `line_irq` never fires.

## Timing
- Reset values:
  - H=0, V=0, flip_q=0.
  - Staging and active registers = parameter defaults; irq_line=0, irq_en=0.
  - lhbl=1, lvbl=1, hsync=0, vsync=0, display_on=1, vrender=1.
  - frame_start=0, line_irq=0, cfg_dout=0.
- Reset wins over `pxl_cen` and `cfg_we` in the same cycle.
- Reset mid-frame restarts at H=V=0 and discards any uncommitted writes.
- Latency: H/V and all derived outputs change on the clk96 edge where `pxl_cen`=1, with zero extra pipeline delay between counters and flags.
- A write in the same clk96 cycle as commit is not committed. Commit takes the pre-write staging value; the new value applies at the following frame start.
- `pxl_cen` held low freezes every output except `cfg_dout`. Pulses stay 0 during the freeze.
- `flip` changes mid-frame are ignored until the next commit.

## Test plan
- Reset, then free-run with `pxl_cen` every 4th clk96. Required response:
  - 432 px/line.
  - lhbl low exactly for H 320..431.
  - hsync high for H 360..379.
  - 263 lines/frame; vsync high for V 244..248.
  - `frame_start` once per 113,616 pixels.
- At V=100, write h_last=383. Required response: line length stays 432 until the frame wraps, then 384 from the H=0,V=0 line. Readback of addr 0 returns 383 one cycle after the request.
- Write irq_line=16 and ctrl=1 before frame start. Required response:
  - `line_irq` pulses exactly once per frame, at H=0, V=16.
  - Writing ctrl=0 stops it from the next frame.
  - irq_line=300 never fires.
- Set `flip`=1 mid-frame. Required response:
  - vrender unchanged until commit.
  - Next frame: V=0 gives vrender 239, V=238 gives 1, V=239 gives 0.
  - V=262 gives vrender 240 (vr=0).
- Assert `cfg_we` (addr 4, data 199) in the commit cycle. Required response: the frame stays 263 lines; the following frame is 200 lines.
- Pull `reset96_n` low for one clk96 at H=200, V=150 after staging v_last=199 uncommitted. Required response: all outputs return to their reset values and timing runs at the defaults (263 lines).

Source files
------------

// File: rtl/raizing_vtimer_prog.sv
// Programmable video timing generator: pixel/line counters, blanking, sync and IRQ pulses.
// Geometry is staged by cfg writes and copied to the active set only when the frame wraps.
module raizing_vtimer_prog #(
  parameter int W        = 9,
  parameter int H_LAST   = 431,
  parameter int H_ACT    = 320,
  parameter int HS_START = 360,
  parameter int HS_END   = 380,
  parameter int V_LAST   = 262,
  parameter int V_ACT    = 240,
  parameter int VS_START = 244,
  parameter int VS_END   = 249
) (
  input  logic         clk96,
  input  logic         reset96_n,
  input  logic         pxl_cen,
  input  logic         flip,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  output logic [W-1:0] cfg_dout,
  output logic [W-1:0] hpos,
  output logic [W-1:0] vpos,
  output logic [W-1:0] vrender,
  output logic         lhbl,
  output logic         lvbl,
  output logic         hsync,
  output logic         vsync,
  output logic         display_on,
  output logic         frame_start,
  output logic         line_irq
);
  localparam int NREG = 10;
  typedef logic [NREG-1:0][W-1:0] regs_t;

  // 0 h_last 1 h_act 2 hs_start 3 hs_end 4 v_last 5 v_act 6 vs_start 7 vs_end 8 irq_line 9 ctrl
  function automatic regs_t defaults();
    regs_t r;
    r    = '0;
    r[0] = W'(H_LAST);
    r[1] = W'(H_ACT);
    r[2] = W'(HS_START);
    r[3] = W'(HS_END);
    r[4] = W'(V_LAST);
    r[5] = W'(V_ACT);
    r[6] = W'(VS_START);
    r[7] = W'(VS_END);
    return r;
  endfunction

  regs_t        st_q, act_q, act_d;
  logic [W-1:0] h_q, h_d, v_q, v_d, vr_d, vrender_q, cfg_dout_q;
  logic         flip_q, flip_d, h_wrap, v_wrap, commit;
  logic         lhbl_q, lvbl_q, hsync_q, vsync_q, fs_q, irq_q;

  // Flags are computed from the next counter values and next active set so
  // they line up with the counters without an extra pipeline stage.
  always_comb begin
    h_wrap = (h_q == act_q[0]);
    v_wrap = (v_q == act_q[4]);
    commit = pxl_cen & h_wrap & v_wrap;
    h_d    = h_q;
    v_d    = v_q;
    if (pxl_cen) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
    end
    act_d  = commit ? st_q : act_q;
    flip_d = commit ? flip : flip_q;
    vr_d   = (v_d == act_d[4]) ? '0 : v_d + 1'b1;
  end

  always_ff @(posedge clk96) begin
    if (!reset96_n) begin
      h_q        <= '0;
      v_q        <= '0;
      flip_q     <= 1'b0;
      st_q       <= defaults();
      act_q      <= defaults();
      lhbl_q     <= 1'b1;
      lvbl_q     <= 1'b1;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      vrender_q  <= W'(1);
      fs_q       <= 1'b0;
      irq_q      <= 1'b0;
      cfg_dout_q <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      flip_q     <= flip_d;
      act_q      <= act_d;
      lhbl_q     <= (h_d < act_d[1]);
      lvbl_q     <= (v_d < act_d[5]);
      hsync_q    <= (h_d >= act_d[2]) && (h_d < act_d[3]);
      vsync_q    <= (v_d >= act_d[6]) && (v_d < act_d[7]);
      vrender_q  <= flip_d ? act_d[5] - vr_d : vr_d;
      fs_q       <= commit;
      irq_q      <= pxl_cen & h_wrap & act_d[9][0] & (v_d == act_d[8]);
      cfg_dout_q <= (cfg_addr < 4'd10) ? st_q[cfg_addr] : '0;
      // Commit above reads the pre-write staging value via non-blocking semantics.
      if (cfg_we && (cfg_addr < 4'd10)) st_q[cfg_addr] <= cfg_data;
    end
  end

  assign hpos        = h_q;
  assign vpos        = v_q;
  assign vrender     = vrender_q;
  assign lhbl        = lhbl_q;
  assign lvbl        = lvbl_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = lhbl_q & lvbl_q;
  assign frame_start = fs_q;
  assign line_irq    = irq_q;
  assign cfg_dout    = cfg_dout_q;
endmodule
